// File: rtl/alu_rs_scheduler_pkg.sv
// alu_rs_scheduler_pkg: shared widths, opcode enum and constants for the ALU reservation station
package alu_rs_scheduler_pkg;
    localparam int OP_BITS = 6;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ROB_BITS = 4;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef enum logic [OP_BITS-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
    } openum;
endpackage

// File: rtl/alu_rs_scheduler_pick.sv
// rs_priority_pick: lowest-index find-first encoder
// ports: req - request vector; found - any request set; idx - lowest set index (0 when none)
module rs_priority_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = W'(i);
    end
    assign found = |req;
endmodule

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: reservation station and one-per-cycle issue scheduler for the shared ALU
// ports: clk_in/rst_in (sync active-high)/rdy_in (global enable), flush (ROB rollback);
//        in_* dispatch interface with full back-pressure; cdb_* and lsb_* result buses
//        for operand wakeup; alu_* registered issue outputs with alu_valid strobe
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int ROB_BITS = alu_rs_scheduler_pkg::ROB_BITS,
    parameter int OP_BITS  = alu_rs_scheduler_pkg::OP_BITS
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [OP_BITS-1:0]  in_op,
    input  logic [DATA_W-1:0]   in_vj,
    input  logic [DATA_W-1:0]   in_vk,
    input  logic                in_qj_valid,
    input  logic                in_qk_valid,
    input  logic [ROB_BITS-1:0] in_qj,
    input  logic [ROB_BITS-1:0] in_qk,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic [ADDR_W-1:0]   in_pc,
    input  logic [ROB_BITS-1:0] in_rob,
    output logic                full,
    input  logic                cdb_valid,
    input  logic [ROB_BITS-1:0] cdb_rob,
    input  logic [DATA_W-1:0]   cdb_value,
    input  logic                lsb_valid,
    input  logic [ROB_BITS-1:0] lsb_rob,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                alu_valid,
    output logic [OP_BITS-1:0]  alu_op,
    output logic [DATA_W-1:0]   alu_rs1,
    output logic [DATA_W-1:0]   alu_rs2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [ADDR_W-1:0]   alu_pc,
    output logic [ROB_BITS-1:0] alu_rob
);
    localparam int IW = $clog2(RS_SIZE);
    typedef struct packed {
        logic                busy;
        logic [OP_BITS-1:0]  op;
        logic [DATA_W-1:0]   vj;
        logic [DATA_W-1:0]   vk;
        logic                qjv;
        logic                qkv;
        logic [ROB_BITS-1:0] qj;
        logic [ROB_BITS-1:0] qk;
        logic [DATA_W-1:0]   imm;
        logic [ADDR_W-1:0]   pc;
        logic [ROB_BITS-1:0] rob;
    } entry_t;
    entry_t [RS_SIZE-1:0] ent;
    entry_t               ins;
    logic [RS_SIZE-1:0]   busy, ready;
    logic                 free_found, rdy_found;
    logic [IW-1:0]        free_idx, rdy_idx;
    // Returns {still_pending, value}; the ALU bus wins if both buses carry the tag.
    function automatic logic [DATA_W:0] wake(input logic qv, input logic [ROB_BITS-1:0] q,
                                             input logic [DATA_W-1:0] v);
        return (qv && cdb_valid && cdb_rob == q) ? {FALSE, cdb_value} :
               (qv && lsb_valid && lsb_rob == q) ? {FALSE, lsb_value} : {qv, v};
    endfunction
    for (genvar i = 0; i < RS_SIZE; i++) begin : g_flag
        assign busy[i]  = ent[i].busy;
        assign ready[i] = ent[i].busy && !ent[i].qjv && !ent[i].qkv;
    end
    assign full = &busy;
    rs_priority_pick #(.N(RS_SIZE)) u_free (.req(~busy), .found(free_found), .idx(free_idx));
    rs_priority_pick #(.N(RS_SIZE)) u_rdy  (.req(ready), .found(rdy_found), .idx(rdy_idx));
    // Incoming entry with same-cycle bus bypass on both operands.
    always_comb begin
        ins = '{busy: TRUE, op: in_op, vj: in_vj, vk: in_vk, qjv: in_qj_valid, qkv: in_qk_valid,
                qj: in_qj, qk: in_qk, imm: in_imm, pc: in_pc, rob: in_rob};
        {ins.qjv, ins.vj} = wake(in_qj_valid, in_qj, in_vj);
        {ins.qkv, ins.vk} = wake(in_qk_valid, in_qk, in_vk);
    end
    // Issue and insert never target the same slot: one is busy, the other free.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ent       <= '0;
            alu_valid <= FALSE;
            alu_op    <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            alu_imm   <= '0;
            alu_pc    <= '0;
            alu_rob   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= FALSE;
                alu_valid <= FALSE;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    {ent[i].qjv, ent[i].vj} <= wake(ent[i].qjv, ent[i].qj, ent[i].vj);
                    {ent[i].qkv, ent[i].vk} <= wake(ent[i].qkv, ent[i].qk, ent[i].vk);
                end
                alu_valid <= rdy_found;
                if (rdy_found) begin
                    alu_op             <= ent[rdy_idx].op;
                    alu_rs1            <= ent[rdy_idx].vj;
                    alu_rs2            <= ent[rdy_idx].vk;
                    alu_imm            <= ent[rdy_idx].imm;
                    alu_pc             <= ent[rdy_idx].pc;
                    alu_rob            <= ent[rdy_idx].rob;
                    ent[rdy_idx].busy  <= FALSE;
                end
                if (in_valid && !full && free_found) ent[free_idx] <= ins;
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: directed scenarios plus randomized run against a behavioural model
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush, in_valid, in_qj_valid, in_qk_valid, cdb_valid, lsb_valid;
    logic [5:0] in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc, cdb_value, lsb_value;
    logic [3:0] in_qj, in_qk, in_rob, cdb_rob, lsb_rob;
    logic full, alu_valid;
    logic [5:0] alu_op;
    logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc;
    logic [3:0] alu_rob;
    int checks = 0, errors = 0;

    always #5 clk_in = ~clk_in;

    alu_rs_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_valid(in_qj_valid), .in_qk_valid(in_qk_valid), .in_qj(in_qj), .in_qk(in_qk),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .lsb_valid(lsb_valid), .lsb_rob(lsb_rob), .lsb_value(lsb_value),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
    );

    typedef struct {
        bit busy, pj, pk;
        logic [5:0] op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0] qj, qk, rob;
    } m_ent_t;
    m_ent_t m[8];
    bit m_valid = 0, m_full = 0;
    logic [5:0] m_op = '0;
    logic [31:0] m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_pc = '0;
    logic [3:0] m_rob = '0;

    function automatic bit heard(input logic [3:0] tag, output logic [31:0] val);
        val = (cdb_valid && cdb_rob == tag) ? cdb_value : lsb_value;
        return (cdb_valid && cdb_rob == tag) || (lsb_valid && lsb_rob == tag);
    endfunction

    task automatic model_edge();
        logic [31:0] v;
        int sel, fr, n;
        if (rst_in) begin
            foreach (m[i]) m[i].busy = 0;
            m_valid = 0; m_full = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0; m_rob = '0;
            return;
        end
        if (!rdy_in) return;
        if (flush) begin
            foreach (m[i]) m[i].busy = 0;
            m_valid = 0; m_full = 0;
            return;
        end
        sel = -1; fr = -1; n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy) n++;
            if (sel < 0 && m[i].busy && !m[i].pj && !m[i].pk) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        m_valid = (sel >= 0);
        if (sel >= 0) begin
            m_op = m[sel].op; m_rs1 = m[sel].vj; m_rs2 = m[sel].vk;
            m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
            m[sel].busy = 0;
        end
        for (int i = 0; i < 8; i++) if (m[i].busy) begin
            if (m[i].pj && heard(m[i].qj, v)) begin m[i].vj = v; m[i].pj = 0; end
            if (m[i].pk && heard(m[i].qk, v)) begin m[i].vk = v; m[i].pk = 0; end
        end
        if (in_valid && n < 8) begin
            m[fr].busy = 1; m[fr].op = in_op; m[fr].imm = in_imm; m[fr].pc = in_pc; m[fr].rob = in_rob;
            m[fr].qj = in_qj; m[fr].qk = in_qk;
            m[fr].pj = in_qj_valid; m[fr].vj = in_vj;
            m[fr].pk = in_qk_valid; m[fr].vk = in_vk;
            if (in_qj_valid && heard(in_qj, v)) begin m[fr].pj = 0; m[fr].vj = v; end
            if (in_qk_valid && heard(in_qk, v)) begin m[fr].pk = 0; m[fr].vk = v; end
        end
        n = 0;
        foreach (m[i]) if (m[i].busy) n++;
        m_full = (n == 8);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; flush = 0; in_valid = 0; cdb_valid = 0; lsb_valid = 0;
        in_op = '0; in_vj = '0; in_vk = '0; in_qj_valid = 0; in_qk_valid = 0; in_qj = '0; in_qk = '0;
        in_imm = '0; in_pc = '0; in_rob = '0; cdb_rob = '0; lsb_rob = '0; cdb_value = '0; lsb_value = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        step();
        step();
        rst_in = 0;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [31:0] vj, vk, input logic pj,
                          input logic [3:0] qj, input logic pk, input logic [3:0] qk,
                          input logic [31:0] imm, pc, input logic [3:0] rob);
        in_valid = 1; in_op = op; in_vj = vj; in_vk = vk; in_qj_valid = pj; in_qj = qj;
        in_qk_valid = pk; in_qk = qk; in_imm = imm; in_pc = pc; in_rob = rob;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(OP_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 3);
        step();
        in_valid = 0; rst_in = 1;
        step();
        rst_in = 0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", alu_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if ({alu_op, alu_rs1, alu_rs2, alu_imm, alu_pc, alu_rob} !== '0) begin errors++; $display("FAIL reset_outs: rs1 %0h rob %0h expected 0", alu_rs1, alu_rob); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_cleared_entry: got %b expected 0", alu_valid); end
    endtask

    task automatic test_add();
        do_reset();
        set_in(OP_ADD, 5, 7, 0, 0, 0, 0, 0, 32'h100, 9);
        step();
        in_valid = 0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL add_early: got %b expected 0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", alu_valid); end
        checks++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin errors++; $display("FAIL add_ops: got %0d,%0d expected 5,7", alu_rs1, alu_rs2); end
        checks++; if (alu_rob !== 4'd9 || alu_op !== OP_ADD || alu_pc !== 32'h100) begin errors++; $display("FAIL add_tag: rob %0d op %0d pc %0h expected 9 %0d 100", alu_rob, alu_op, alu_pc, OP_ADD); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL add_once: got %b expected 0", alu_valid); end
    endtask

    task automatic test_wakeup();
        do_reset();
        set_in(OP_ADDI, 0, 32'h1234, 1, 3, 0, 0, 16, 32'h200, 4);
        step();
        in_valid = 0;
        step();
        cdb_valid = 1; cdb_rob = 3; cdb_value = 100;
        step();
        cdb_valid = 0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_early: got %b expected 0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL wake_valid: got %b expected 1", alu_valid); end
        checks++; if (alu_rs1 !== 32'd100 || alu_imm !== 32'd16 || alu_rob !== 4'd4) begin errors++; $display("FAIL wake_ops: rs1 %0d imm %0d rob %0d expected 100 16 4", alu_rs1, alu_imm, alu_rob); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_in(OP_SUB, 11, 0, 0, 0, 1, 2, 0, 32'h300, 6);
        lsb_valid = 1; lsb_rob = 2; lsb_value = 32'hDEAD;
        step();
        in_valid = 0; lsb_valid = 0;
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", alu_valid); end
        checks++; if (alu_rs2 !== 32'hDEAD || alu_rs1 !== 32'd11 || alu_rob !== 4'd6) begin errors++; $display("FAIL bypass_ops: rs1 %0h rs2 %0h rob %0d expected b dead 6", alu_rs1, alu_rs2, alu_rob); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(OP_ADD, 0, 32'h50 + i, 1, 4'(i), 0, 0, i, 0, 4'(i));
            step();
        end
        in_valid = 0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b expected 1", full); end
        set_in(OP_OR, 1, 2, 0, 0, 0, 0, 0, 0, 15);
        step();
        in_valid = 0;
        checks++; if (full !== 1'b1 || alu_valid !== 1'b0) begin errors++; $display("FAIL full_drop: full %b valid %b expected 1 0", full, alu_valid); end
        cdb_valid = 1; cdb_rob = 5; cdb_value = 1005;
        step();
        cdb_valid = 0;
        checks++; if (full !== 1'b1 || alu_valid !== 1'b0) begin errors++; $display("FAIL full_wake: full %b valid %b expected 1 0", full, alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd5 || alu_rs1 !== 32'd1005 || alu_rs2 !== 32'h55) begin errors++; $display("FAIL full_issue: valid %b rob %0d rs1 %0d rs2 %0h expected 1 5 1005 55", alu_valid, alu_rob, alu_rs1, alu_rs2); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b expected 0", full); end
        for (int t = 0; t < 8; t++) if (t != 5) begin
            cdb_valid = 1; cdb_rob = 4'(t); cdb_value = 1000 + t;
            step();
            cdb_valid = 0;
            step();
            checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'(t) || alu_rs1 !== 32'(1000 + t)) begin errors++; $display("FAIL full_drain%0d: valid %b rob %0d rs1 %0d", t, alu_valid, alu_rob, alu_rs1); end
        end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL full_dropped_issued: rob %0d expected no issue", alu_rob); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_in(OP_AND, 0, 0, 1, 4'(i), 0, 0, 0, 0, 4'(i));
            step();
        end
        set_in(OP_AND, 9, 9, 0, 0, 0, 0, 0, 0, 4);
        step();
        set_in(OP_OR, 1, 1, 0, 0, 0, 0, 0, 0, 12);
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        checks++; if (alu_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_now: valid %b full %b expected 0 0", alu_valid, full); end
        for (int i = 1; i <= 6; i++) begin
            cdb_valid = (i <= 4); cdb_rob = 4'(i); cdb_value = 77;
            step();
            checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_late%0d: rob %0d issued, expected none", i, alu_rob); end
        end
        cdb_valid = 0;
    endtask

    task automatic test_rdy();
        do_reset();
        set_in(OP_ADD, 0, 1, 1, 6, 0, 0, 0, 0, 11);
        step();
        set_in(OP_XOR, 3, 4, 0, 0, 0, 0, 0, 0, 10);
        step();
        in_valid = 0; rdy_in = 0; cdb_valid = 1; cdb_rob = 6; cdb_value = 77;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_frozen%0d: got %b expected 0", i, alu_valid); end
        end
        rdy_in = 1; cdb_valid = 0;
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd10 || alu_rs1 !== 32'd3) begin errors++; $display("FAIL rdy_resume: valid %b rob %0d rs1 %0d expected 1 10 3", alu_valid, alu_rob, alu_rs1); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rdy_no_capture: got %b expected 0", alu_valid); end
        cdb_valid = 1; cdb_rob = 6; cdb_value = 55;
        step();
        cdb_valid = 0;
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd11 || alu_rs1 !== 32'd55) begin errors++; $display("FAIL rdy_late_wake: valid %b rob %0d rs1 %0d expected 1 11 55", alu_valid, alu_rob, alu_rs1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst_in = ($urandom_range(0, 149) == 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_op = 6'($urandom_range(0, 28));
            in_vj = $urandom; in_vk = $urandom; in_imm = $urandom; in_pc = $urandom;
            in_qj_valid = $urandom_range(0, 1); in_qk_valid = $urandom_range(0, 1);
            in_qj = 4'($urandom_range(0, 7)); in_qk = 4'($urandom_range(0, 7)); in_rob = 4'($urandom);
            cdb_valid = $urandom_range(0, 1); lsb_valid = $urandom_range(0, 1);
            cdb_rob = 4'($urandom_range(0, 7)); lsb_rob = 4'($urandom_range(0, 7));
            if (cdb_valid && lsb_valid && cdb_rob == lsb_rob) lsb_rob = lsb_rob ^ 4'd1;
            cdb_value = $urandom; lsb_value = $urandom;
            step();
            checks++; if (alu_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, alu_valid, m_valid); end
            checks++; if (full !== m_full) begin errors++; $display("FAIL rnd_full@%0d: got %b expected %b", c, full, m_full); end
            if (m_valid) begin
                checks++;
                if ({alu_op, alu_rs1, alu_rs2, alu_imm, alu_pc, alu_rob} !== {m_op, m_rs1, m_rs2, m_imm, m_pc, m_rob}) begin
                    errors++;
                    $display("FAIL rnd_fields@%0d: got op %0d rs1 %0h rs2 %0h imm %0h pc %0h rob %0d expected %0d %0h %0h %0h %0h %0d",
                             c, alu_op, alu_rs1, alu_rs2, alu_imm, alu_pc, alu_rob, m_op, m_rs1, m_rs2, m_imm, m_pc, m_rob);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_add();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_rdy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
